peripheral_apb4_msi_collector: RTL

//  APB4 slave behind the AHB3-to-APB bridge that collects MSI messages into an interrupt queue.

---
 rtl/peripheral_msi_pkg.sv | 16 +
 rtl/peripheral_msi_fifo.sv | 60 ++++++
 rtl/peripheral_apb4_msi_collector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/peripheral_msi_pkg.sv
// Shared register map and bit positions for the APB4 MSI collector.
package peripheral_msi_pkg;
  localparam logic [2:0] REG_DOORBELL = 3'd0;
  localparam logic [2:0] REG_POP      = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_TIMEOUT  = 3'd4;

  localparam int ST_CNT_W     = 8;
  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_OVF       = 10;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_THR_LSB = 8;
  localparam int THR_W        = 8;
endpackage

// File: rtl/peripheral_msi_fifo.sv
// Vector-ID FIFO with an explicit count; a push into a full FIFO is accepted only alongside a pop.
module peripheral_msi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/peripheral_apb4_msi_collector.sv
// APB4 slave collecting MSI vector IDs from doorbell writes and a hardware port,
// with threshold/timeout coalescing into a level interrupt.
module peripheral_apb4_msi_collector
  import peripheral_msi_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 32,
  parameter int VECTOR_W       = 8,
  parameter int DEPTH          = 16,
  parameter int TIMER_W        = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      hw_valid_i,
  input  logic [VECTOR_W-1:0]       hw_vector_i,
  output logic                      irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]          sel;
  logic                acc, stall, xfer, wr, rd;
  logic                db_push, pop, push, drop;
  logic [VECTOR_W-1:0] push_vec, fifo_data;
  logic [CW-1:0]       count;
  logic                full, empty;
  logic [APB_DATA_WIDTH-1:0] rdata;

  logic                en_q, en_d;
  logic [THR_W-1:0]    thr_q, thr_d, thr_eff;
  logic [TIMER_W-1:0]  timeout_q, timeout_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                ovf_q, ovf_d;
  logic                irq_q, irq_d;

  logic                unused_ok;
  assign unused_ok = ^{PADDR, PWDATA};

  assign sel   = PADDR[4:2];
  assign acc   = PSEL & PENABLE;
  // Hardware owns the single write port; a colliding doorbell waits it out.
  assign stall = acc & PWRITE & (sel == REG_DOORBELL) & hw_valid_i;
  assign xfer  = acc & ~stall;
  assign wr    = xfer & PWRITE;
  assign rd    = xfer & ~PWRITE;

  assign db_push  = wr & (sel == REG_DOORBELL);
  assign pop      = rd & (sel == REG_POP) & ~empty;
  assign push     = hw_valid_i | db_push;
  assign push_vec = hw_valid_i ? hw_vector_i : PWDATA[VECTOR_W-1:0];
  assign drop     = push & full & ~pop;

  peripheral_msi_fifo #(.W(VECTOR_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (push_vec),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      REG_POP: if (!empty) begin
        rdata[APB_DATA_WIDTH-1] = 1'b1;
        rdata[VECTOR_W-1:0]     = fifo_data;
      end
      REG_STATUS: begin
        rdata[ST_CNT_W-1:0] = ST_CNT_W'(count);
        rdata[ST_EMPTY]     = empty;
        rdata[ST_FULL]      = full;
        rdata[ST_OVF]       = ovf_q;
      end
      REG_CTRL: begin
        rdata[CTRL_EN]                 = en_q;
        rdata[CTRL_THR_LSB +: THR_W]   = thr_q;
      end
      REG_TIMEOUT: rdata[TIMER_W-1:0] = timeout_q;
      default: rdata = '0;
    endcase
  end

  // During reset any in-flight access is completed cleanly.
  assign PREADY  = RST | ~stall;
  assign PSLVERR = ~RST & db_push & full;
  assign PRDATA  = (RST | ~(acc & ~PWRITE)) ? '0 : rdata;
  assign irq_o   = irq_q;

  assign thr_eff = (thr_q == '0) ? THR_W'(1) : thr_q;

  always_comb begin
    en_d      = en_q;
    thr_d     = thr_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
    timer_d   = timer_q;
    if (wr && sel == REG_CTRL) begin
      en_d  = PWDATA[CTRL_EN];
      thr_d = PWDATA[CTRL_THR_LSB +: THR_W];
    end
    if (wr && sel == REG_TIMEOUT) timeout_d = PWDATA[TIMER_W-1:0];
    if (wr && sel == REG_STATUS && PWDATA[ST_OVF]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
    if (empty || pop)       timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + 1'b1;
    irq_d = en_q & ((9'(count) >= 9'(thr_eff)) |
                    ((timeout_q != '0) & (timer_q >= timeout_q)) |
                    ovf_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q      <= 1'b0;
      thr_q     <= '0;
      timeout_q <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      thr_q     <= thr_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
    end
  end
endmodule
